// File: rtl/la_capture_sequencer.sv
// Purpose : steps both logic-analyser SRAMs through one capture: SPI EQIO, quad WRITE @0, then sample streaming.
// Latency : every output is registered; sram_dout follows la_data by one clock during CAPTURE.
// Backpr. : none; the SRAMs accept one nibble per chip per clock, so start/abort are plain pulses.
module la_capture_sequencer #(
  parameter int LA_WIDTH = 8,
  parameter int LA_CHIPS = 2,
  parameter int POST_W   = 16,
  parameter int CNT_W    = 18
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic                i_trigger,
  input  logic [POST_W-1:0]   i_samples_post,
  input  logic [LA_WIDTH-1:0] i_la_data,
  output logic [LA_CHIPS-1:0] o_sram_cs,
  output logic                o_sram_clk_en,
  output logic                o_sram_oe,
  output logic [LA_WIDTH-1:0] o_sram_dout,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_triggered,
  output logic [CNT_W-1:0]    o_sample_count
);

  // Sequencer states. Values are kept stable for software that decodes them
  // through debug taps.
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_EQIO = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
  localparam logic [2:0] S_WCMD = 3'd3;
  localparam logic [2:0] S_CAP  = 3'd4;
  localparam logic [2:0] S_STOP = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  // SPI "enter quad I/O" opcode, shifted out MSB first on sio0 of every chip.
  localparam logic [7:0] EQIO_CMD = 8'h38;
  // Quad WRITE opcode nibbles; the six address nibbles that follow are all zero.
  localparam logic [3:0] WCMD_NIB = 4'h2;

  localparam logic [POST_W-1:0] POST_ONE = POST_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  // Architectural state.
  logic [2:0]          r_state;
  logic [2:0]          r_pos;        // bit/nibble index inside EQIO and WCMD
  logic [POST_W-1:0]   r_post_len;   // samples_post captured at start
  logic [POST_W-1:0]   r_post_left;  // post-trigger samples still to write after the current one
  logic                r_triggered;
  logic [CNT_W-1:0]    r_count;

  // Registered pin-facing outputs.
  logic [LA_CHIPS-1:0] r_cs;
  logic                r_clk_en;
  logic                r_oe;
  logic [LA_WIDTH-1:0] r_dout;
  logic                r_busy;
  logic                r_done;

  // Next-state values.
  logic [2:0]          w_state_nxt;
  logic [2:0]          w_pos_nxt;
  logic [POST_W-1:0]   w_post_len_nxt;
  logic [POST_W-1:0]   w_post_left_nxt;
  logic                w_trig_nxt;
  logic                w_start_ok;
  logic                w_busy_now;
  logic                w_drive_nxt;
  logic                w_busy_nxt;
  logic [LA_WIDTH-1:0] w_dout_nxt;
  logic [CNT_W-1:0]    w_count_nxt;

  assign w_busy_now = (r_state != S_IDLE) && (r_state != S_DONE);

  // Sequencing: abort preempts everything while busy; start is only honoured when idle or done.
  always_comb begin
    w_state_nxt     = r_state;
    w_pos_nxt       = r_pos;
    w_post_len_nxt  = r_post_len;
    w_post_left_nxt = r_post_left;
    w_trig_nxt      = r_triggered;
    w_start_ok      = 1'b0;
    if (w_busy_now && i_abort) begin
      w_state_nxt = S_STOP;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            w_start_ok     = 1'b1;
            w_state_nxt    = S_EQIO;
            w_pos_nxt      = 3'd0;
            w_post_len_nxt = i_samples_post;
            w_trig_nxt     = 1'b0;
          end
        end
        S_EQIO: begin
          if (r_pos == 3'd7) begin
            w_state_nxt = S_GAP;
            w_pos_nxt   = 3'd0;
          end else begin
            w_pos_nxt = r_pos + 3'd1;
          end
        end
        S_GAP: begin
          // One deselected cycle terminates the SPI-mode EQIO command.
          w_state_nxt = S_WCMD;
          w_pos_nxt   = 3'd0;
        end
        S_WCMD: begin
          if (r_pos == 3'd7) begin
            w_state_nxt = S_CAP;
            w_pos_nxt   = 3'd0;
          end else begin
            w_pos_nxt = r_pos + 3'd1;
          end
        end
        S_CAP: begin
          if (!r_triggered) begin
            if (i_trigger) begin
              // The trigger sample itself is post sample 1, so 0 and 1 both end here.
              w_trig_nxt = 1'b1;
              if (r_post_len <= POST_ONE) begin
                w_state_nxt = S_STOP;
              end else begin
                w_post_left_nxt = r_post_len - POST_ONE;
              end
            end
          end else begin
            if (r_post_left <= POST_ONE) begin
              w_state_nxt = S_STOP;
            end else begin
              w_post_left_nxt = r_post_left - POST_ONE;
            end
          end
        end
        S_STOP: begin
          w_state_nxt = S_DONE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Output decode from the state about to be entered, so the pins are pure flops.
  always_comb begin
    w_drive_nxt = (w_state_nxt == S_EQIO) || (w_state_nxt == S_WCMD) || (w_state_nxt == S_CAP);
    w_busy_nxt  = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
    w_dout_nxt  = '0;
    case (w_state_nxt)
      S_EQIO: begin
        // Chips are still in SPI mode: only sio0 of each chip carries the opcode.
        for (int c = 0; c < LA_CHIPS; c++) begin
          w_dout_nxt[4*c] = EQIO_CMD[3'd7 - w_pos_nxt];
        end
      end
      S_WCMD: begin
        for (int c = 0; c < LA_CHIPS; c++) begin
          w_dout_nxt[4*c +: 4] = (w_pos_nxt == 3'd1) ? WCMD_NIB : 4'h0;
        end
      end
      S_CAP: begin
        w_dout_nxt = i_la_data;
      end
      default: begin
        w_dout_nxt = '0;
      end
    endcase
  end

  // Sample counter: cleared by an accepted start, +1 for every sample presented;
  // it wraps with the SRAM address so pre-trigger data forms a ring.
  always_comb begin
    w_count_nxt = r_count;
    if (w_start_ok) begin
      w_count_nxt = '0;
    end else if (w_state_nxt == S_CAP) begin
      w_count_nxt = r_count + CNT_ONE;
    end
  end

  // State and output registers; async reset deselects the SRAMs immediately.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= S_IDLE;
      r_pos       <= 3'd0;
      r_post_len  <= '0;
      r_post_left <= '0;
      r_triggered <= 1'b0;
      r_count     <= '0;
      r_cs        <= '1;
      r_clk_en    <= 1'b0;
      r_oe        <= 1'b0;
      r_dout      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pos       <= w_pos_nxt;
      r_post_len  <= w_post_len_nxt;
      r_post_left <= w_post_left_nxt;
      r_triggered <= w_trig_nxt;
      r_count     <= w_count_nxt;
      r_cs        <= w_drive_nxt ? '0 : '1;
      r_clk_en    <= w_drive_nxt;
      r_oe        <= w_drive_nxt;
      r_dout      <= w_dout_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= (w_state_nxt == S_DONE);
    end
  end

  assign o_sram_cs      = r_cs;
  assign o_sram_clk_en  = r_clk_en;
  assign o_sram_oe      = r_oe;
  assign o_sram_dout    = r_dout;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_triggered    = r_triggered;
  assign o_sample_count = r_count;

endmodule

// File: tb/tb_la_capture_sequencer.sv
// Bench for la_capture_sequencer: directed captures checked against a cycle-schedule model
// plus literal expectations for the EQIO/WCMD patterns, capture lengths and final counts.
// The DUT counter is narrowed to 4 bits so wrap-around is reachable in a short run.
module tb_la_capture_sequencer;

  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        trigger = 1'b0;
  logic [15:0] samples_post = 16'd0;
  logic [7:0]  la_data = 8'd0;
  logic [1:0]  cs;
  logic        clk_en;
  logic        oe;
  logic [7:0]  dout;
  logic        busy;
  logic        done;
  logic        triggered;
  logic [CW-1:0] count;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  la_capture_sequencer #(.LA_WIDTH(8), .LA_CHIPS(2), .POST_W(16), .CNT_W(CW)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_start(start), .i_abort(abort),
    .i_trigger(trigger), .i_samples_post(samples_post), .i_la_data(la_data),
    .o_sram_cs(cs), .o_sram_clk_en(clk_en), .o_sram_oe(oe), .o_sram_dout(dout),
    .o_busy(busy), .o_done(done), .o_triggered(triggered), .o_sample_count(count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The run is a schedule measured in clocks since start: 8 opcode bits, one gap,
  // 8 command nibbles, then samples until the post-trigger quota or an abort.
  logic [7:0] eqio_cmd = 8'h38;
  bit   m_run = 0, m_stop = 0, m_done = 0, m_trig = 0;
  int   m_t = 0, m_post = 0, m_left = 0, m_count = 0;
  logic [7:0] m_dout = 8'd0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_run = 0; m_stop = 0; m_done = 0; m_trig = 0;
      m_t = 0; m_count = 0; m_dout = 8'd0;
    end else if (m_stop) begin
      m_stop = 0;
      m_done = 1;
    end else if (m_run) begin
      if (abort) begin
        m_run = 0; m_stop = 1;
      end else begin
        bit ending;
        ending = 0;
        if (m_t >= 17) begin
          if (!m_trig && trigger) begin
            m_trig = 1;
            m_left = m_post;
          end
          if (m_trig) begin
            m_left--;
            if (m_left <= 0) ending = 1;
          end
        end
        if (ending) begin
          m_run = 0; m_stop = 1;
        end else begin
          m_t++;
          if (m_t >= 17) begin
            m_count = (m_count + 1) % (1 << CW);
            m_dout  = la_data;
          end
        end
      end
    end else if (start) begin
      m_run = 1; m_done = 0; m_trig = 0; m_t = 0; m_count = 0;
      m_post = int'(samples_post);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  logic [7:0] e_dout;
  bit         e_drv;
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      e_drv = m_run && (m_t != 8);
      if (!e_drv) e_dout = 8'h00;
      else if (m_t < 8) e_dout = {3'b000, eqio_cmd[7-m_t], 3'b000, eqio_cmd[7-m_t]};
      else if (m_t <= 16) e_dout = (m_t == 10) ? 8'h22 : 8'h00;
      else e_dout = m_dout;
      chk("cyc_cs", 32'(cs), e_drv ? 32'd0 : 32'd3);
      chk("cyc_clk_en", 32'(clk_en), 32'(e_drv));
      chk("cyc_oe", 32'(oe), 32'(e_drv));
      chk("cyc_dout", 32'(dout), 32'(e_dout));
      chk("cyc_busy", 32'(busy), 32'(m_run || m_stop));
      chk("cyc_done", 32'(done), 32'(m_done));
      chk("cyc_triggered", 32'(triggered), 32'(m_trig));
      chk("cyc_count", 32'(count), 32'(m_count));
    end
  end

  // ---------------- stimulus helpers ----------------
  int cnt_hist [0:63];

  task automatic cyc();
    @(negedge clk);
    la_data = 8'($urandom);
  endtask

  // Start a run and walk EQIO, GAP and WCMD, checking the literal command patterns.
  task automatic preamble(input logic [15:0] post);
    logic [7:0]  b0, b4;
    logic [31:0] nl, nh;
    nl = 32'd0; nh = 32'd0; b0 = 8'd0; b4 = 8'd0;
    cyc(); samples_post = post; start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(); start = 1'b0;
      b0[7-i] = dout[0];
      b4[7-i] = dout[4];
    end
    chk("eqio_sio0", 32'(b0), 32'h38);
    chk("eqio_sio4", 32'(b4), 32'h38);
    cyc();
    chk("gap_cs", 32'(cs), 32'd3);
    for (int i = 0; i < 8; i++) begin
      cyc();
      nl = {nl[27:0], dout[3:0]};
      nh = {nh[27:0], dout[7:4]};
    end
    chk("wcmd_chip0", nl, 32'h0200_0000);
    chk("wcmd_chip1", nh, 32'h0200_0000);
  endtask

  // Drive capture cycles (numbered from 1) until the SRAMs are deselected.
  task automatic capture(input int trig_at, input int abort_at, input int start_a,
                         input int start_b, input int limit, output int ncap);
    int k;
    bit fin;
    k = 0; fin = 0;
    while (!fin) begin
      cyc();
      trigger = 1'b0; abort = 1'b0; start = 1'b0;
      if (cs != 2'b00) begin
        fin = 1;
      end else begin
        k++;
        if (k < 64) cnt_hist[k] = int'(count);
        trigger = (k == trig_at);
        abort   = (k == abort_at);
        start   = (k == start_a) || (k == start_b);
        if (k >= limit) begin
          n_cmp++; n_err++;
          $display("FAIL capture_bound: still capturing after %0d cycles", k);
          fin = 1;
        end
      end
    end
    ncap = k;
    chk("stop_busy", 32'(busy), 32'd1);
    chk("stop_done", 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    repeat (3) cyc();
    chk("rst_cs", 32'(cs), 32'd3);
    chk("rst_clk_en", 32'(clk_en), 32'd0);
    chk("rst_oe", 32'(oe), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_trig", 32'(triggered), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    cmp_en = 1'b1;
    rst_n = 1'b1;
    cyc();

    // 1: post=3, trigger on capture cycle 10 -> 12 samples.
    preamble(16'd3);
    capture(10, 0, 0, 0, 60, n);
    chk("t1_ncap", 32'(n), 32'd12);
    cyc();
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_cs", 32'(cs), 32'd3);
    chk("t1_count", 32'(count), 32'd12);
    chk("t1_trig", 32'(triggered), 32'd1);

    // 2: post=0, trigger on the first capture cycle -> one sample.
    preamble(16'd0);
    capture(1, 0, 0, 0, 60, n);
    chk("t2_ncap", 32'(n), 32'd1);
    cyc();
    chk("t2_count", 32'(count), 32'd1);
    chk("t2_done", 32'(done), 32'd1);

    // 3: no trigger, counter wraps 15 -> 0, abort on cycle 20.
    preamble(16'd5);
    capture(0, 20, 0, 0, 60, n);
    chk("t3_ncap", 32'(n), 32'd20);
    chk("t3_cnt15", 32'(cnt_hist[15]), 32'd15);
    chk("t3_cnt16", 32'(cnt_hist[16]), 32'd0);
    chk("t3_cnt17", 32'(cnt_hist[17]), 32'd1);
    cyc();
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_trig", 32'(triggered), 32'd0);
    chk("t3_count", 32'(count), 32'd4);

    // 4: abort while the third WCMD nibble is on the bus.
    cyc(); samples_post = 16'd9; start = 1'b1;
    repeat (8) begin cyc(); start = 1'b0; end
    cyc();
    repeat (3) cyc();
    abort = 1'b1;
    cyc(); abort = 1'b0;
    chk("t4_cs", 32'(cs), 32'd3);
    chk("t4_clk_en", 32'(clk_en), 32'd0);
    chk("t4_done_stop", 32'(done), 32'd0);
    cyc();
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);

    // 5: restart from DONE; post latched as 7, later changed to 1; start while
    //    busy at cycle 3, start+abort together at cycle 8.
    preamble(16'd7);
    samples_post = 16'd1;
    capture(5, 8, 3, 8, 60, n);
    chk("t5_ncap", 32'(n), 32'd8);
    cyc();
    chk("t5_trig", 32'(triggered), 32'd1);
    chk("t5_count", 32'(count), 32'd8);
    chk("t5_done", 32'(done), 32'd1);

    // Post-count boundaries: 1 ends on the trigger sample, 2 one sample later.
    preamble(16'd1);
    capture(4, 0, 0, 0, 60, n);
    chk("p1_ncap", 32'(n), 32'd4);
    cyc();
    preamble(16'd2);
    capture(1, 0, 0, 0, 60, n);
    chk("p2_ncap", 32'(n), 32'd2);
    cyc();

    // 6: async reset between edges during capture.
    preamble(16'd100);
    repeat (3) cyc();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t6_cs", 32'(cs), 32'd3);
    chk("t6_oe", 32'(oe), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_clk_en", 32'(clk_en), 32'd0);
    chk("t6_count", 32'(count), 32'd0);
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (2) cyc();
    chk("t6_idle_cs", 32'(cs), 32'd3);
    chk("t6_idle_done", 32'(done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
